// File: rtl/im_loader_if.sv
// Loader-side bus bundle: byte-stream handshake, frame control/status and the
// instruction-memory write port. The master drives bytes; the slave is the loader.
interface im_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/im_loader.sv
// Framed byte-stream loader: LEN_HI, LEN_LO, 4N big-endian payload bytes, CSUM.
// Writes words to BASE_ADDR+k, flags checksum errors and address overflow.
module im_loader #(
    parameter int MEM_SIZE  = 256,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 1
) (
    input  logic        clk,
    input  logic        reset,
    im_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE
    } state_t;

    state_t            r_state;
    logic [7:0]        r_sum;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_shift;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic [7:0]        w_sum_next;
    logic [31:0]       w_target;
    logic              w_overflow;
    logic              w_last_word;

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_sum_next  = r_sum + bus.in_data;
    // Address is computed wide so that running past MEM_SIZE is detected, never wrapped.
    assign w_target    = 32'(BASE_ADDR) + {16'd0, r_word_cnt};
    assign w_overflow  = (w_target >= 32'(MEM_SIZE));
    assign w_last_word = (({1'b0, r_word_cnt} + 17'd1) == {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sum       <= '0;
            r_len_hi    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(BASE_ADDR);
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_LEN_HI;
                        r_err      <= 1'b0;
                        r_sum      <= '0;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= bus.in_data;
                        r_sum    <= w_sum_next;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len   <= {r_len_hi, bus.in_data};
                        r_sum   <= w_sum_next;
                        r_state <= ({r_len_hi, bus.in_data} != 16'd0) ? S_DATA : S_CSUM;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_sum      <= w_sum_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_overflow) begin
                                r_err <= 1'b1;
                            end else begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_target[ADDR_W-1:0];
                                r_mem_wdata <= {r_shift, bus.in_data};
                            end
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (w_last_word)
                                r_state <= S_CSUM;
                        end else begin
                            r_shift <= {r_shift[15:0], bus.in_data};
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_sum      <= w_sum_next;
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                        if (w_sum_next != 8'd0)
                            r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: valid frames, bad checksum, empty frames,
// overflow with stalls, reset mid-frame and start-while-busy.
module tb_im_loader;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(8)) bus();

    im_loader #(.MEM_SIZE(256), .ADDR_W(8), .BASE_ADDR(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int ready_viol = 0;
    logic last_done_err = 1'b0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_xfer[$];

    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready)
            xfer_cnt <= xfer_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_xfer.push_back(xfer_cnt);
        end
        if (bus.done) begin
            done_cnt      = done_cnt + 1;
            last_done_err = bus.err;
        end
        if (bus.in_ready && (!bus.busy || bus.done))
            ready_viol = ready_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t bytes, input int maxgap);
        foreach (bytes[i])
            send_byte(bytes[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called right after the CSUM transfer: the loader must now be in DONE.
    task automatic check_end(input string name, input logic exp_err, input int d0, input int nwr);
        chk({name, "_done"}, 32'(bus.done), 32'd1);
        chk({name, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({name, "_ready_in_done"}, 32'(bus.in_ready), 32'd0);
        tick();
        chk({name, "_done_fall"}, 32'(bus.done), 32'd0);
        chk({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
        chk({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        $display("frame %s: writes=%0d done_err=%b", name, nwr, last_done_err);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({name, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({name, "_mem_addr"}, 32'(bus.mem_addr), 32'd1);
        chk({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
        chk({name, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        int w0, d0, x0;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Single word 0x20080005 at address 1.
        w0 = wr_addr.size(); d0 = done_cnt;
        do_start();
        chk("t1_busy_rise", 32'(bus.busy), 32'd1);
        chk("t1_ready_rise", 32'(bus.in_ready), 32'd1);
        f = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD2};
        send_frame(f, 0);
        check_end("single", 1'b0, d0, wr_addr.size() - w0);
        chk("t1_nwr", 32'(wr_addr.size() - w0), 32'd1);
        chk("t1_addr", 32'(wr_addr[w0]), 32'd1);
        chk("t1_data", wr_data[w0], 32'h20080005);

        // Same frame with a bad checksum: word still written, err held.
        tick();
        w0 = wr_addr.size(); d0 = done_cnt;
        do_start();
        f = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
        send_frame(f, 0);
        check_end("badcsum", 1'b1, d0, wr_addr.size() - w0);
        chk("t2_nwr", 32'(wr_addr.size() - w0), 32'd1);
        chk("t2_addr", 32'(wr_addr[w0]), 32'd1);
        chk("t2_data", wr_data[w0], 32'h20080005);
        repeat (3) tick();
        chk("t2_err_hold", 32'(bus.err), 32'd1);

        // N=0, good checksum; the start clears the held err.
        w0 = wr_addr.size(); d0 = done_cnt;
        do_start();
        chk("t3_err_clear", 32'(bus.err), 32'd0);
        f = {8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        check_end("empty", 1'b0, d0, wr_addr.size() - w0);
        chk("t3_nwr", 32'(wr_addr.size() - w0), 32'd0);

        // N=0, bad checksum.
        tick();
        w0 = wr_addr.size(); d0 = done_cnt;
        do_start();
        f = {8'h00, 8'h00, 8'h01};
        send_frame(f, 0);
        check_end("empty_bad", 1'b1, d0, wr_addr.size() - w0);
        chk("t4_nwr", 32'(wr_addr.size() - w0), 32'd0);

        // N=256 with random in_valid gaps: word 255 would hit address 256.
        tick();
        w0 = wr_addr.size(); d0 = done_cnt; x0 = xfer_cnt;
        do_start();
        f = {8'h01, 8'h00};
        repeat (1024) f.push_back(8'h00);
        f.push_back(8'hFF);
        send_frame(f, 2);
        check_end("overflow", 1'b1, d0, wr_addr.size() - w0);
        chk("t5_nwr", 32'(wr_addr.size() - w0), 32'd255);
        if (wr_addr.size() - w0 == 255) begin
            chk("t5_first_xfer", 32'(wr_xfer[w0] - x0), 32'd6);
            for (int i = 0; i < 255; i++) begin
                chk("t5_addr", 32'(wr_addr[w0 + i]), 32'(i + 1));
                chk("t5_data", wr_data[w0 + i], 32'd0);
                if (i > 0) chk("t5_spacing", 32'(wr_xfer[w0 + i] - wr_xfer[w0 + i - 1]), 32'd4);
            end
        end

        // Reset after 2 payload bytes of a 3-word frame, with a simultaneous start.
        tick();
        w0 = wr_addr.size();
        do_start();
        f = {8'h00, 8'h03, 8'h11, 8'h22};
        send_frame(f, 0);
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check_reset_vals("midreset");
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        repeat (10) tick();
        bus.in_valid = 1'b0;
        chk("t6_no_write", 32'(wr_addr.size() - w0), 32'd0);
        chk("t6_busy_idle", 32'(bus.busy), 32'd0);
        $display("frame midreset: writes=%0d", wr_addr.size() - w0);

        // Clean frame after the reset.
        w0 = wr_addr.size(); d0 = done_cnt;
        do_start();
        f = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC7};
        send_frame(f, 0);
        check_end("after_reset", 1'b0, d0, wr_addr.size() - w0);
        chk("t7_nwr", 32'(wr_addr.size() - w0), 32'd1);
        chk("t7_addr", 32'(wr_addr[w0]), 32'd1);
        chk("t7_data", wr_data[w0], 32'hDEADBEEF);

        // start pulsed mid-DATA must not disturb a 2-word frame.
        tick();
        w0 = wr_addr.size(); d0 = done_cnt;
        do_start();
        f = {8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        bus.start = 1'b1;
        send_byte(8'h01, 0);
        bus.start = 1'b0;
        f = {8'h00, 8'h00, 8'h00, 8'h02, 8'hFB};
        send_frame(f, 0);
        check_end("start_busy", 1'b0, d0, wr_addr.size() - w0);
        chk("t8_nwr", 32'(wr_addr.size() - w0), 32'd2);
        if (wr_addr.size() - w0 == 2) begin
            chk("t8_addr0", 32'(wr_addr[w0]), 32'd1);
            chk("t8_data0", wr_data[w0], 32'h00000001);
            chk("t8_addr1", 32'(wr_addr[w0 + 1]), 32'd2);
            chk("t8_data1", wr_data[w0 + 1], 32'h00000002);
        end

        tick();
        chk("ready_idle_done", 32'(ready_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/im_loader.md
# im_loader

Byte-stream program loader that writes 32-bit instruction words into the instruction memory's write port before (or between) program runs. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian MIPS words, writes them to consecutive word addresses from a base index, and validates an 8-bit frame checksum. While it is loading, it holds the datapath in stall through `busy`.

## Interface
- `MEM_SIZE`, 256: instruction memory depth in words. Also the address limit.
- `ADDR_W`, 8: word-address width. Must satisfy 2^ADDR_W >= MEM_SIZE.
- `BASE_ADDR`, 1: word index of the first payload word. Word 0 is left untouched.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame. Ignored unless the FSM is in IDLE.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `mem_we`  out  1  instruction-memory write enable.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  high from the accepted `start` until DONE is exited. Drives the datapath stall.
- `done`  out  1  one-cycle pulse at frame end.
- `err`  out  1  frame failed (checksum mismatch or overflow). Held until the next accepted `start` or `reset`.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N payload bytes (each word MSB first), then CSUM.
- Checksum rule: the 8-bit modulo-256 sum of every frame byte, including the length bytes and CSUM, must be 0x00.
- FSM states are IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE.
  - IDLE -> LEN_HI on `start`. This transition clears `err`, the running sum, the byte counter and the word counter.
  - LEN_HI -> LEN_LO on a transfer.
  - LEN_LO -> DATA on a transfer if N != 0. If N == 0, LEN_LO -> CSUM.
  - DATA: a 2-bit byte counter shifts bytes into a 32-bit word register. On the 4th transfer the word is complete. DATA -> CSUM after word N completes.
  - CSUM -> DONE on a transfer. `err` is set if the sum including CSUM is not 0x00.
  - DONE -> IDLE unconditionally after one cycle.
- Write address for word k (k = 0..N-1) is BASE_ADDR + k.
- Overflow: if BASE_ADDR + k >= MEM_SIZE, that word's write is suppressed and `err` is set.
  - Bytes are still consumed and the frame runs to completion.
  - Writes never wrap to low addresses.
- Words already written are never rolled back, even on a checksum error. `err` tells software to rerun the load.
- `start` while `busy` is ignored.
- Reset mid-frame: on the next edge the FSM returns to IDLE, all outputs take their reset values, and no further writes occur.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0.
- `in_ready`=1 in LEN_HI, LEN_LO, DATA and CSUM. It is 0 in IDLE and DONE. It is registered from state and has no combinational path from `in_valid`.
- One byte per cycle at most. A `in_valid` gap stalls the FSM with no state loss.
- `busy` rises the cycle after `start` is accepted. It falls on the cycle after DONE, together with the return to IDLE.
- `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - `mem_we` is high for exactly one cycle, in the cycle after the 4th byte of a word transfers.
  - `mem_addr` and `mem_wdata` are stable during that cycle.
- Back-to-back words give `mem_we` high at most once every 4 cycles.
- `done` is high exactly in the DONE cycle, which is the cycle after the CSUM transfer. `err` is valid in that same cycle.
- Minimum frame length in cycles is 3 + 4N transfers, plus the `start` cycle and the DONE cycle.

## Test plan
- Single word: `start`, then bytes 00 01 20 08 00 05 D2 -> exactly one `mem_we` pulse with addr=1, wdata=0x20080005; `done` pulse; `err`=0; `busy` low after DONE.
- Bad checksum: same frame with CSUM=D3 -> word still written to addr 1; `done` pulse with `err`=1. `err` holds until the next `start`, which clears it.
- N=0: bytes 00 00 00 -> no `mem_we`; `done` pulse, `err`=0. Then N=0 with CSUM=01 -> `err`=1.
- Overflow and stalls: N=256 (bytes 01 00, payload all 00, CSUM FF), with `in_valid` toggled randomly.
  - Required: 255 writes, addr 1..255 in order, each 4 transfers apart.
  - The 256th word produces no write; `err`=1 at `done`.
  - `in_ready` is never high in IDLE or DONE.
- Reset mid-frame: assert `reset` after the 2nd payload byte of a 3-word frame -> no `mem_we` afterwards; all outputs at reset values.
  - A `start` in the same cycle as `reset` is ignored.
  - A subsequent clean 1-word frame writes addr 1 correctly.
- Start while busy: pulse `start` during DATA -> no effect on the frame; the write sequence and `done` are unchanged.
